// File: rtl/procyon_mhq_ooo.sv
// Out-of-order miss handling queue: merges misses per cacheline, tracks tagged
// BIU reads that may complete in any order, and fills the dcache in completion order.
module procyon_mhq_ooo #(
    parameter int OPTN_DATA_WIDTH          = 32,
    parameter int OPTN_ADDR_WIDTH          = 32,
    parameter int OPTN_MHQ_DEPTH           = 8,
    parameter int OPTN_DC_LINE_SIZE        = 32,
    parameter int OPTN_MHQ_MAX_OUTSTANDING = 4,
    parameter int PCYN_LSU_FUNC_WIDTH      = 3,
    parameter int MHQ_IDX_WIDTH            = $clog2(OPTN_MHQ_DEPTH),
    parameter int DC_LINE_WIDTH            = OPTN_DC_LINE_SIZE * 8
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           i_mhq_lookup_valid,
    input  logic                           i_mhq_lookup_dc_hit,
    input  logic [OPTN_ADDR_WIDTH-1:0]     i_mhq_lookup_addr,
    input  logic [PCYN_LSU_FUNC_WIDTH-1:0] i_mhq_lookup_lsu_func,
    input  logic [OPTN_DATA_WIDTH-1:0]     i_mhq_lookup_data,
    input  logic                           i_mhq_lookup_we,
    output logic [MHQ_IDX_WIDTH-1:0]       o_mhq_lookup_tag,
    output logic                           o_mhq_lookup_retry,
    output logic                           o_mhq_lookup_replay,
    output logic                           o_mhq_fill_en,
    output logic [MHQ_IDX_WIDTH-1:0]       o_mhq_fill_tag,
    output logic                           o_mhq_fill_dirty,
    output logic [OPTN_ADDR_WIDTH-1:0]     o_mhq_fill_addr,
    output logic [DC_LINE_WIDTH-1:0]       o_mhq_fill_data,
    output logic                           o_biu_en,
    output logic [OPTN_ADDR_WIDTH-1:0]     o_biu_addr,
    output logic [MHQ_IDX_WIDTH-1:0]       o_biu_tag,
    input  logic                           i_biu_ack,
    input  logic                           i_biu_done,
    input  logic [MHQ_IDX_WIDTH-1:0]       i_biu_done_tag,
    input  logic [DC_LINE_WIDTH-1:0]       i_biu_data
);

    localparam int OFF_W = $clog2(OPTN_DC_LINE_SIZE);
    localparam int LA_W  = OPTN_ADDR_WIDTH - OFF_W;
    localparam int CNT_W = $clog2(OPTN_MHQ_MAX_OUTSTANDING + 1);
    localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] LSU_FUNC_SB = PCYN_LSU_FUNC_WIDTH'(5);
    localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] LSU_FUNC_SH = PCYN_LSU_FUNC_WIDTH'(6);

    // state | meaning
    // FREE  | entry unused
    // WAIT  | miss allocated, BIU read not yet accepted
    // REQ   | BIU read accepted, awaiting response
    // DONE  | line complete, waiting to be picked for fill
    typedef enum logic [1:0] {MHQ_FREE, MHQ_WAIT, MHQ_REQ, MHQ_DONE} mhq_state_t;

    mhq_state_t                   state_q [OPTN_MHQ_DEPTH];
    mhq_state_t                   state_d [OPTN_MHQ_DEPTH];
    logic [LA_W-1:0]              line_q  [OPTN_MHQ_DEPTH];
    logic [DC_LINE_WIDTH-1:0]     data_q  [OPTN_MHQ_DEPTH];
    logic [OPTN_DC_LINE_SIZE-1:0] mask_q  [OPTN_MHQ_DEPTH];
    logic [OPTN_MHQ_DEPTH-1:0]    dirty_q;
    logic [CNT_W-1:0]             cnt_q, cnt_next;
    logic [MHQ_IDX_WIDTH-1:0]     rr_q, rr_base, rr_start, idx;

    logic [LA_W-1:0]              lookup_line;
    logic [OFF_W-1:0]             lookup_off;
    logic                         lookup_active, replay, alloc, retry, wr_en;
    logic                         fill_found, free_found, match_found, iss_found, issue_ok;
    logic [MHQ_IDX_WIDTH-1:0]     fill_sel, free_idx, match_idx, wr_idx, iss_sel, tag_next;
    logic [OPTN_DC_LINE_SIZE-1:0] size_mask, st_mask;
    logic [DC_LINE_WIDTH-1:0]     st_data;
    logic                         biu_acked, done_valid;

    always_comb begin
        lookup_line   = i_mhq_lookup_addr[OPTN_ADDR_WIDTH-1:OFF_W];
        lookup_off    = i_mhq_lookup_addr[OFF_W-1:0];
        lookup_active = i_mhq_lookup_valid && !i_mhq_lookup_dc_hit;
        fill_found    = 1'b0;
        fill_sel      = '0;
        free_found    = 1'b0;
        free_idx      = '0;
        match_found   = 1'b0;
        match_idx     = '0;
        for (int i = OPTN_MHQ_DEPTH - 1; i >= 0; i--) begin
            if (state_q[i] == MHQ_DONE) begin
                fill_found = 1'b1;
                fill_sel   = MHQ_IDX_WIDTH'(i);
            end
            if (state_q[i] == MHQ_FREE) begin
                free_found = 1'b1;
                free_idx   = MHQ_IDX_WIDTH'(i);
            end else if (line_q[i] == lookup_line) begin
                match_found = 1'b1;
                match_idx   = MHQ_IDX_WIDTH'(i);
            end
        end
        // A line leaving for the dcache this cycle must be replayed, never re-merged
        replay   = lookup_active && fill_found && (line_q[fill_sel] == lookup_line);
        alloc    = lookup_active && !replay && !match_found && free_found;
        retry    = lookup_active && !replay && !match_found && !free_found;
        wr_idx   = match_found ? match_idx : free_idx;
        wr_en    = i_mhq_lookup_we && (alloc || (lookup_active && !replay && match_found));
        tag_next = (alloc || (lookup_active && !replay && match_found)) ? wr_idx : '0;

        case (i_mhq_lookup_lsu_func)
            LSU_FUNC_SB: size_mask = OPTN_DC_LINE_SIZE'(4'h1);
            LSU_FUNC_SH: size_mask = OPTN_DC_LINE_SIZE'(4'h3);
            default:     size_mask = OPTN_DC_LINE_SIZE'(4'hF);
        endcase
        st_mask = size_mask << lookup_off;
        st_data = DC_LINE_WIDTH'(i_mhq_lookup_data) << {lookup_off, 3'b000};
    end

    always_comb begin
        biu_acked  = o_biu_en && i_biu_ack;
        done_valid = i_biu_done && (state_q[i_biu_done_tag] == MHQ_REQ);
        case ({biu_acked, done_valid})
            2'b10:   cnt_next = cnt_q + CNT_W'(1);
            2'b01:   cnt_next = cnt_q - CNT_W'(1);
            default: cnt_next = cnt_q;
        endcase
        rr_base   = biu_acked ? o_biu_tag : rr_q;
        rr_start  = rr_base + MHQ_IDX_WIDTH'(1);
        iss_found = 1'b0;
        iss_sel   = '0;
        idx       = '0;
        for (int k = OPTN_MHQ_DEPTH - 1; k >= 0; k--) begin
            idx = rr_start + MHQ_IDX_WIDTH'(k);
            if (state_q[idx] == MHQ_WAIT && !(biu_acked && idx == o_biu_tag)) begin
                iss_found = 1'b1;
                iss_sel   = idx;
            end
        end
        issue_ok = iss_found && (cnt_next < CNT_W'(OPTN_MHQ_MAX_OUTSTANDING));
    end

    always_comb begin
        for (int i = 0; i < OPTN_MHQ_DEPTH; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                MHQ_FREE: if (alloc && free_idx == MHQ_IDX_WIDTH'(i)) state_d[i] = MHQ_WAIT;
                MHQ_WAIT: if (biu_acked && o_biu_tag == MHQ_IDX_WIDTH'(i)) state_d[i] = MHQ_REQ;
                MHQ_REQ:  if (done_valid && i_biu_done_tag == MHQ_IDX_WIDTH'(i)) state_d[i] = MHQ_DONE;
                MHQ_DONE: if (fill_found && fill_sel == MHQ_IDX_WIDTH'(i)) state_d[i] = MHQ_FREE;
                default:  state_d[i] = MHQ_FREE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < OPTN_MHQ_DEPTH; i++) begin
                state_q[i] <= MHQ_FREE;
                mask_q[i]  <= '0;
            end
            dirty_q             <= '0;
            cnt_q               <= '0;
            rr_q                <= '0;
            o_biu_en            <= 1'b0;
            o_biu_addr          <= '0;
            o_biu_tag           <= '0;
            o_mhq_lookup_tag    <= '0;
            o_mhq_lookup_retry  <= 1'b0;
            o_mhq_lookup_replay <= 1'b0;
            o_mhq_fill_en       <= 1'b0;
            o_mhq_fill_tag      <= '0;
            o_mhq_fill_dirty    <= 1'b0;
            o_mhq_fill_addr     <= '0;
            o_mhq_fill_data     <= '0;
        end else begin
            for (int i = 0; i < OPTN_MHQ_DEPTH; i++) state_q[i] <= state_d[i];
            if (alloc) begin
                mask_q[free_idx]  <= wr_en ? st_mask : '0;
                dirty_q[free_idx] <= wr_en;
            end else if (wr_en) begin
                mask_q[wr_idx]  <= mask_q[wr_idx] | st_mask;
                dirty_q[wr_idx] <= 1'b1;
            end
            cnt_q <= cnt_next;
            if (biu_acked) rr_q <= o_biu_tag;
            // The pending request is frozen until the BIU takes it
            if (!o_biu_en || i_biu_ack) begin
                o_biu_en <= issue_ok;
                if (issue_ok) begin
                    o_biu_tag  <= iss_sel;
                    o_biu_addr <= {line_q[iss_sel], {OFF_W{1'b0}}};
                end
            end
            o_mhq_lookup_tag    <= tag_next;
            o_mhq_lookup_retry  <= retry;
            o_mhq_lookup_replay <= replay;
            o_mhq_fill_en       <= fill_found;
            if (fill_found) begin
                o_mhq_fill_tag   <= fill_sel;
                o_mhq_fill_dirty <= dirty_q[fill_sel];
                o_mhq_fill_addr  <= {line_q[fill_sel], {OFF_W{1'b0}}};
                o_mhq_fill_data  <= data_q[fill_sel];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) line_q[free_idx] <= lookup_line;
        for (int i = 0; i < OPTN_MHQ_DEPTH; i++) begin
            for (int b = 0; b < OPTN_DC_LINE_SIZE; b++) begin
                if (wr_en && wr_idx == MHQ_IDX_WIDTH'(i) && st_mask[b]) begin
                    data_q[i][b*8 +: 8] <= st_data[b*8 +: 8];
                end else if (done_valid && i_biu_done_tag == MHQ_IDX_WIDTH'(i) && !mask_q[i][b]) begin
                    data_q[i][b*8 +: 8] <= i_biu_data[b*8 +: 8];
                end
            end
        end
    end

endmodule
